// File: rtl/systolic_mac_pe.sv
// Multiply-accumulate processing element for a systolic array: registered
// east/south operand pass-through, local accumulator, daisy-chained drain path.
module systolic_mac_pe #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic              clear_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  input  logic              drain_in,
  input  logic [ACC_W-1:0]  c_in,
  input  logic              c_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              clear_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_vld_out,
  output logic              ovf,
  output logic              state_dbg
);
  // Handshake: a value is consumed only in a cycle where its valid flag is high;
  // there is no ready/backpressure, every stage accepts one item per clock.
  typedef enum logic {ST_ACCUM = 1'b0, ST_PASS = 1'b1} state_t;

  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam bit IS_SAT    = (SATURATE != 0);
  localparam int EXT_P     = ACC_W + 1 - 2 * DATA_W;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_vld_q, a_vld_d, clear_q, clear_d, b_vld_q, b_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d, c_q, c_d;
  logic              c_vld_q, c_vld_d, ovf_q, ovf_d;

  logic                capture, mac_fire, fresh, sum_ovf;
  logic [2*DATA_W-1:0] a_x, b_x, prod;
  logic [ACC_W:0]      prod_x, base_x, sum_x;
  logic [ACC_W-1:0]    sum_res;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (drain_in)  state_d = ST_PASS;
      ST_PASS:  if (!drain_in) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    capture  = (state_q == ST_ACCUM) && drain_in;
    mac_fire = a_vld_in && b_vld_in;
    fresh    = clear_in || capture;

    // Extended operands make the low 2*DATA_W product bits exact for either signedness.
    a_x    = {{DATA_W{IS_SIGNED & a_in[DATA_W-1]}}, a_in};
    b_x    = {{DATA_W{IS_SIGNED & b_in[DATA_W-1]}}, b_in};
    prod   = a_x * b_x;
    prod_x = {{EXT_P{IS_SIGNED & prod[2*DATA_W-1]}}, prod};
    base_x = fresh ? '0 : {IS_SIGNED & acc_q[ACC_W-1], acc_q};
    sum_x  = base_x + prod_x;

    if (IS_SIGNED) sum_ovf = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    else           sum_ovf = sum_x[ACC_W];

    sum_res = sum_x[ACC_W-1:0];
    if (sum_ovf && IS_SAT) begin
      if (!IS_SIGNED)        sum_res = '1;
      else if (sum_x[ACC_W]) sum_res = {1'b1, {(ACC_W-1){1'b0}}};
      else                   sum_res = {1'b0, {(ACC_W-1){1'b1}}};
    end

    a_d     = a_in;
    a_vld_d = a_vld_in;
    clear_d = clear_in;
    b_d     = b_in;
    b_vld_d = b_vld_in;

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (capture) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    if (mac_fire) begin
      acc_d = sum_res;
      ovf_d = (fresh ? 1'b0 : ovf_q) | sum_ovf;
    end

    c_d     = c_q;
    c_vld_d = 1'b0;
    if (state_q == ST_PASS) begin
      c_d     = c_in;
      c_vld_d = c_vld_in;
    end else if (capture) begin
      c_d     = acc_q;
      c_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
      clear_q <= 1'b0;
      b_q     <= '0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      c_q     <= '0;
      c_vld_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      clear_q <= clear_d;
      b_q     <= b_d;
      b_vld_q <= b_vld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      c_q     <= c_d;
      c_vld_q <= c_vld_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = a_vld_q;
  assign clear_out = clear_q;
  assign b_out     = b_q;
  assign b_vld_out = b_vld_q;
  assign c_out     = c_q;
  assign c_vld_out = c_vld_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: four parameterisations share one stimulus stream and
// are checked every cycle against an integer-arithmetic model; a 2-PE chain is checked directly.
module tb_systolic_mac_pe;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic [7:0]  a_in, b_in;
  logic        a_vld_in, clear_in, b_vld_in, drain_in, c_vld_in;
  logic [23:0] c_in_s;

  logic [7:0]  a_o [4];
  logic [7:0]  b_o [4];
  logic        av_o [4];
  logic        cl_o [4];
  logic        bv_o [4];
  logic        cv_o [4];
  logic        ov_o [4];
  logic        st_o [4];
  logic [23:0] c_def;
  logic [15:0] c16 [1:3];

  int cfg_w [4]   = '{24, 16, 16, 16};
  bit cfg_s [4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit cfg_sat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1)) u_def (
    .clock(clock), .reset(reset), .a_in(a_in), .a_vld_in(a_vld_in), .clear_in(clear_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .drain_in(drain_in), .c_in(c_in_s), .c_vld_in(c_vld_in),
    .a_out(a_o[0]), .a_vld_out(av_o[0]), .clear_out(cl_o[0]), .b_out(b_o[0]), .b_vld_out(bv_o[0]),
    .c_out(c_def), .c_vld_out(cv_o[0]), .ovf(ov_o[0]), .state_dbg(st_o[0]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .a_in(a_in), .a_vld_in(a_vld_in), .clear_in(clear_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .drain_in(drain_in), .c_in(c_in_s[15:0]), .c_vld_in(c_vld_in),
    .a_out(a_o[1]), .a_vld_out(av_o[1]), .clear_out(cl_o[1]), .b_out(b_o[1]), .b_vld_out(bv_o[1]),
    .c_out(c16[1]), .c_vld_out(cv_o[1]), .ovf(ov_o[1]), .state_dbg(st_o[1]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .a_in(a_in), .a_vld_in(a_vld_in), .clear_in(clear_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .drain_in(drain_in), .c_in(c_in_s[15:0]), .c_vld_in(c_vld_in),
    .a_out(a_o[2]), .a_vld_out(av_o[2]), .clear_out(cl_o[2]), .b_out(b_o[2]), .b_vld_out(bv_o[2]),
    .c_out(c16[2]), .c_vld_out(cv_o[2]), .ovf(ov_o[2]), .state_dbg(st_o[2]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u_uns (
    .clock(clock), .reset(reset), .a_in(a_in), .a_vld_in(a_vld_in), .clear_in(clear_in),
    .b_in(b_in), .b_vld_in(b_vld_in), .drain_in(drain_in), .c_in(c_in_s[15:0]), .c_vld_in(c_vld_in),
    .a_out(a_o[3]), .a_vld_out(av_o[3]), .clear_out(cl_o[3]), .b_out(b_o[3]), .b_vld_out(bv_o[3]),
    .c_out(c16[3]), .c_vld_out(cv_o[3]), .ovf(ov_o[3]), .state_dbg(st_o[3]));

  // ---------------- two-PE drain chain ----------------
  logic [7:0]  ch_a0, ch_b0, ch_a1, ch_b1;
  logic        ch_v, ch_clr, ch_drain;
  logic [23:0] ch_c0, ch_c1;
  logic        ch_cv0, ch_cv1;
  logic [7:0]  ch_ao0, ch_ao1, ch_bo0, ch_bo1;
  logic        ch_x [10];

  systolic_mac_pe u_pe0 (
    .clock(clock), .reset(reset), .a_in(ch_a0), .a_vld_in(ch_v), .clear_in(ch_clr),
    .b_in(ch_b0), .b_vld_in(ch_v), .drain_in(ch_drain), .c_in(24'd0), .c_vld_in(1'b0),
    .a_out(ch_ao0), .a_vld_out(ch_x[0]), .clear_out(ch_x[1]), .b_out(ch_bo0), .b_vld_out(ch_x[2]),
    .c_out(ch_c0), .c_vld_out(ch_cv0), .ovf(ch_x[3]), .state_dbg(ch_x[4]));

  systolic_mac_pe u_pe1 (
    .clock(clock), .reset(reset), .a_in(ch_a1), .a_vld_in(ch_v), .clear_in(ch_clr),
    .b_in(ch_b1), .b_vld_in(ch_v), .drain_in(ch_drain), .c_in(ch_c0), .c_vld_in(ch_cv0),
    .a_out(ch_ao1), .a_vld_out(ch_x[5]), .clear_out(ch_x[6]), .b_out(ch_bo1), .b_vld_out(ch_x[7]),
    .c_out(ch_c1), .c_vld_out(ch_cv1), .ovf(ch_x[8]), .state_dbg(ch_x[9]));

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_bits(input longint v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 64'(v) & m;
  endfunction

  // ---------------- behavioural model ----------------
  // Accumulators are held as true integers; range limits come straight from the width and signedness.
  longint      m_acc [4];
  bit          m_ovf [4];
  bit          m_pass [4];
  bit          m_cv [4];
  logic [63:0] m_c [4];
  logic [7:0]  m_a, m_b;
  bit          m_av, m_cl, m_bv;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_a <= '0; m_b <= '0; m_av <= 1'b0; m_cl <= 1'b0; m_bv <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_acc[i] <= 0; m_ovf[i] <= 1'b0; m_pass[i] <= 1'b0; m_cv[i] <= 1'b0; m_c[i] <= '0;
      end
    end else begin
      m_a <= a_in; m_b <= b_in; m_av <= a_vld_in; m_cl <= clear_in; m_bv <= b_vld_in;
      for (int i = 0; i < 4; i++) begin
        longint pa, pb, sum, hi, lo, span, nacc;
        bit cap, nov, of;
        cap  = !m_pass[i] && drain_in;
        nacc = cap ? 0 : m_acc[i];
        nov  = cap ? 1'b0 : m_ovf[i];
        if (m_pass[i]) begin
          m_c[i]  <= to_bits(longint'(c_in_s), cfg_w[i]);
          m_cv[i] <= c_vld_in;
        end else begin
          m_cv[i] <= cap;
          if (cap) m_c[i] <= to_bits(m_acc[i], cfg_w[i]);
        end
        m_pass[i] <= drain_in;
        if (a_vld_in && b_vld_in) begin
          pa   = cfg_s[i] ? longint'($signed(a_in)) : longint'(a_in);
          pb   = cfg_s[i] ? longint'($signed(b_in)) : longint'(b_in);
          span = longint'(1) <<< cfg_w[i];
          hi   = cfg_s[i] ? (span / 2) - 1 : span - 1;
          lo   = cfg_s[i] ? -(span / 2) : 0;
          sum  = ((clear_in || cap) ? 0 : m_acc[i]) + pa * pb;
          of   = (sum > hi) || (sum < lo);
          if (sum > hi)      nacc = cfg_sat[i] ? hi : sum - span;
          else if (sum < lo) nacc = cfg_sat[i] ? lo : sum + span;
          else               nacc = sum;
          nov = ((clear_in || cap) ? 1'b0 : nov) | of;
        end
        m_acc[i] <= nacc;
        m_ovf[i] <= nov;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input int i, input logic [63:0] c);
    chk($sformatf("pe%0d_a_out", i), 64'(a_o[i]), 64'(m_a));
    chk($sformatf("pe%0d_a_vld_out", i), 64'(av_o[i]), 64'(m_av));
    chk($sformatf("pe%0d_clear_out", i), 64'(cl_o[i]), 64'(m_cl));
    chk($sformatf("pe%0d_b_out", i), 64'(b_o[i]), 64'(m_b));
    chk($sformatf("pe%0d_b_vld_out", i), 64'(bv_o[i]), 64'(m_bv));
    chk($sformatf("pe%0d_c_out", i), c, m_c[i]);
    chk($sformatf("pe%0d_c_vld_out", i), 64'(cv_o[i]), 64'(m_cv[i]));
    chk($sformatf("pe%0d_ovf", i), 64'(ov_o[i]), 64'(m_ovf[i]));
    chk($sformatf("pe%0d_state", i), 64'(st_o[i]), 64'(m_pass[i]));
  endtask

  always @(negedge clock) begin
    cmp_inst(0, 64'(c_def));
    for (int i = 1; i < 4; i++) cmp_inst(i, 64'(c16[i]));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] a, input logic av, input logic cl,
                      input logic [7:0] b, input logic bv, input logic dr);
    a_in = a; a_vld_in = av; clear_in = cl; b_in = b; b_vld_in = bv; drain_in = dr;
    @(negedge clock);
  endtask

  task automatic idle(input logic dr);
    step(8'd0, 1'b0, 1'b0, 8'd0, 1'b0, dr);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    a_in = '0; b_in = '0; a_vld_in = 1'b0; clear_in = 1'b0; b_vld_in = 1'b0;
    drain_in = 1'b0; c_in_s = '0; c_vld_in = 1'b0;
    ch_a0 = '0; ch_b0 = '0; ch_a1 = '0; ch_b1 = '0; ch_v = 1'b0; ch_clr = 1'b0; ch_drain = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_c_vld", 64'(cv_o[0]), 64'd0);
    chk("rst_c_out", 64'(c_def), 64'd0);
    chk("rst_a_out", 64'(a_o[0]), 64'd0);
    chk("rst_state", 64'(st_o[0]), 64'd0);
    reset = 1'b1;

    // 3*2 (clear) + 4*5 + (-1)*7 = 19
    step(8'd3, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    step(8'd4, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0, 8'd7, 1'b1, 1'b0);
    idle(1'b1);
    chk("dflt_c_out", 64'(c_def), 64'd19);
    chk("dflt_c_vld", 64'(cv_o[0]), 64'd1);
    idle(1'b0);
    chk("dflt_c_vld_drop", 64'(cv_o[0]), 64'd0);

    // lone a operand: passes through, no MAC
    step(8'h5A, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    chk("pt_a_out", 64'(a_o[0]), 64'h5A);
    chk("pt_b_vld_out", 64'(bv_o[0]), 64'd0);
    chk("pt_b_out", 64'(b_o[0]), 64'h33);
    idle(1'b1);
    chk("pt_acc_unchanged", 64'(c_def), 64'd0);
    idle(1'b0);

    // 127*127 three times: 48387
    step(8'd127, 1'b1, 1'b1, 8'd127, 1'b1, 1'b0);
    step(8'd127, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    step(8'd127, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    chk("sat_ovf", 64'(ov_o[1]), 64'd1);
    chk("wrap_ovf", 64'(ov_o[2]), 64'd1);
    chk("def_no_ovf", 64'(ov_o[0]), 64'd0);
    step(8'd1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    chk("clear_resets_ovf", 64'(ov_o[1]), 64'd0);
    step(8'd127, 1'b1, 1'b1, 8'd127, 1'b1, 1'b0);
    step(8'd127, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    step(8'd127, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    idle(1'b1);
    chk("sat_max", 64'(c16[1]), 64'h7FFF);
    chk("wrap_val", 64'(c16[2]), 64'hBD03);
    chk("def_48387", 64'(c_def), 64'd48387);
    chk("drain_clears_ovf", 64'(ov_o[1]), 64'd0);
    idle(1'b0);

    // -128*127 three times: -48768
    step(8'h80, 1'b1, 1'b1, 8'd127, 1'b1, 1'b0);
    step(8'h80, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    step(8'h80, 1'b1, 1'b0, 8'd127, 1'b1, 1'b0);
    idle(1'b1);
    chk("sat_min", 64'(c16[1]), 64'h8000);
    chk("wrap_neg", 64'(c16[2]), 64'h4180);
    idle(1'b0);

    // capture coinciding with MAC 2*3 while acc = 10
    step(8'd10, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    step(8'd2, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1);
    chk("cap_mac_c_out", 64'(c_def), 64'd10);
    chk("cap_mac_c_vld", 64'(cv_o[0]), 64'd1);
    idle(1'b0);
    idle(1'b1);
    chk("cap_mac_fresh_acc", 64'(c_def), 64'd6);
    idle(1'b0);

    // async reset while in PASS with acc = 19
    c_in_s = 24'h00ABCD; c_vld_in = 1'b1;
    idle(1'b1);
    step(8'd3, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);
    step(8'd4, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b0, 8'd7, 1'b1, 1'b1);
    chk("pass_c_out", 64'(c_def), 64'hABCD);
    chk("pass_state", 64'(st_o[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_c_out", 64'(c_def), 64'd0);
    chk("arst_c_vld", 64'(cv_o[0]), 64'd0);
    chk("arst_a_out", 64'(a_o[0]), 64'd0);
    chk("arst_state", 64'(st_o[0]), 64'd0);
    chk("arst_c16", 64'(c16[1]), 64'd0);
    @(negedge clock);
    reset = 1'b1; c_in_s = '0; c_vld_in = 1'b0;
    idle(1'b1);
    chk("post_rst_capture_vld", 64'(cv_o[0]), 64'd1);
    chk("post_rst_acc_zero", 64'(c_def), 64'd0);
    idle(1'b0);

    // two-PE chain: PE0 acc = 9, PE1 acc = 5
    ch_a0 = 8'd3; ch_b0 = 8'd3; ch_a1 = 8'd5; ch_b1 = 8'd1; ch_v = 1'b1; ch_clr = 1'b1;
    idle(1'b0);
    ch_v = 1'b0; ch_clr = 1'b0; ch_drain = 1'b1;
    idle(1'b0);
    chk("chain_first", 64'(ch_c1), 64'd5);
    chk("chain_first_vld", 64'(ch_cv1), 64'd1);
    idle(1'b0);
    chk("chain_second", 64'(ch_c1), 64'd9);
    chk("chain_second_vld", 64'(ch_cv1), 64'd1);
    ch_drain = 1'b0;
    idle(1'b0);
    chk("chain_done_vld", 64'(ch_cv1), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
# systolic_mac_pe

Parametrised multiply-accumulate processing element for the systolic array. It is the successor to the fixed 8-bit element. Operands travel east (`a`) and south (`b`) through one register stage each, and each operand carries a valid flag. The PE accumulates products locally with signed/unsigned and saturate/wrap options. Results leave on a daisy-chained drain path that shifts accumulators out of a column without stopping the array.

## Interface
Parameters:
- `DATA_W`, 8: operand width.
- `ACC_W`, 24: accumulator and drain width; must be ≥ 2*DATA_W.
- `SIGNED`, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `a_in` in DATA_W: west operand.
- `a_vld_in` in 1: `a_in` valid.
- `clear_in` in 1: first-product flag, travels with `a`.
- `b_in` in DATA_W: north operand.
- `b_vld_in` in 1: `b_in` valid.
- `drain_in` in 1: drain request level.
- `c_in` in ACC_W: drain chain from the upstream PE.
- `c_vld_in` in 1: `c_in` valid.
- `a_out`, `a_vld_out`, `clear_out` out DATA_W/1/1: registered copies of the `a` inputs.
- `b_out`, `b_vld_out` out DATA_W/1: registered copies of the `b` inputs.
- `c_out` out ACC_W: drain chain output.
- `c_vld_out` out 1: `c_out` valid.
- `ovf` out 1: sticky overflow flag for the current accumulation.

## Operation
- Pass-through: `a_out`, `a_vld_out`, `clear_out`, `b_out` and `b_vld_out` register their inputs every cycle, unconditionally.
  - Data registers update even when their valid flag is low.
- MAC fires when `a_vld_in & b_vld_in`. The product is computed at full width 2*DATA_W, then sign- or zero-extended to ACC_W per `SIGNED`.
  - `clear_in` = 1: `acc <= product` and `ovf <= 0`.
  - `clear_in` = 0: `acc <= acc + product`.
- Overflow is detected against the signed or unsigned ACC_W range.
  - `SATURATE` = 1: clamp to the max or min representable value and set `ovf`.
  - `SATURATE` = 0: wrap and set `ovf`.
  - `ovf` stays set until a clear-MAC, a drain capture, or reset.
- No MAC fires when only one of the two valids is high. The lone operand still propagates with its valid flag.
- Drain FSM has two states:
  - ACCUM: on `drain_in` = 1, capture. `c_out <= acc`, `c_vld_out <= 1`, `acc <= 0`, `ovf <= 0`, go to PASS. With `drain_in` = 0, `c_vld_out <= 0`.
  - PASS: `c_out <= c_in`, `c_vld_out <= c_vld_in`. Return to ACCUM when `drain_in` = 0. On that cycle `c_vld_out <= c_vld_in` still applies.
- Capture and MAC in the same cycle: `c_out` receives the pre-cycle `acc`. The product is written to `acc` as a fresh accumulation, as if `clear_in` = 1, with ovf evaluated on the product alone.
- MACs continue normally in PASS.
- Chain usage: driving `drain_in` high for N cycles on an N-deep column emits each PE's accumulator in order. The bottom PE's value appears first.

## Timing
- All outputs are 0 and the FSM is in ACCUM while `reset` is low. Deassertion takes effect at the next clock edge.
- Operand pass-through latency: 1 cycle.
- MAC latency: a product sampled at edge k is included in `acc` after edge k. It is visible on `c_out` one cycle after a capture at edge k+1 or later.
- Drain: capture at edge k puts the value on `c_out` after edge k. Each PASS cycle adds 1 cycle per hop.
- Reset asserted mid-accumulation or mid-drain: `acc`, `ovf`, `c_out`, `c_vld_out` and the FSM clear immediately, without waiting for a clock edge. A drain in flight is lost.
- Back-to-back clear-MACs are legal at full rate. There is no stall or backpressure.

## Test plan
- Defaults: a=3,b=2 (clear), then a=4,b=5, a=-1,b=7, all valid. After the 3rd edge `acc` = 6+20-7 = 19; pulsing `drain_in` gives `c_out` = 19, `c_vld_out` = 1 for one cycle.
- Pass-through with `a_vld_in` = 1 and `b_vld_in` = 0: `a_out` follows `a_in` 1 cycle later, `acc` is unchanged, `b_vld_out` = 0.
- SIGNED=1, SATURATE=1, DATA_W=8, ACC_W=16: repeat 127*127 three times. Required: `acc` clamps at 32767 and `ovf` = 1. With SATURATE=0: `acc` = 48387-65536 = -17149 and `ovf` = 1.
- Capture coinciding with a MAC of 2*3 while `acc` = 10: `c_out` = 10. Next `acc` = 6.
- Two-PE chain: PE1 `acc` = 5, PE0 `acc` = 9, PE1 `c_in` fed from PE0's `c_out`, `drain_in` high for 2 cycles. PE1 `c_out` reads 5 then 9, with `c_vld_out` high for 2 cycles.
- Drive `reset` low asynchronously between edges with `acc` = 19 in PASS. All outputs go to 0 at once, and the FSM is in ACCUM after release.
